// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: NZCV bit positions, ARM condition
// codes, ALU op encodings and the execute controller state encoding.
package alu_pkg;

  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_C = 1;
  localparam int CC_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_ORR = 5'd3;
  localparam logic [4:0] OP_EOR = 5'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// ARM condition evaluator: NZCV flags + 4-bit condition field -> pass.
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[CC_N];
  assign z = flags[CC_Z];
  assign c = flags[CC_C];
  assign v = flags[CC_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: conditionally drives the external ALU, owns the
// NZCV register and hands results to writeback over valid/ready.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic [3:0]        issue_cond,
  input  logic              issue_setflags,
  input  logic [RD_W-1:0]   issue_rd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_cond_code,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_executed,
  output logic [3:0]        flags
);

  state_e state_q, state_d;
  logic   rdy_q;
  logic   setflags_q;
  logic   cond_pass;
  logic   accept;

  cond_eval u_cond_eval (
    .flags (flags),
    .cond  (issue_cond),
    .pass  (cond_pass)
  );

  // rdy_q keeps issue_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_ready = 1'b0;
    wb_valid    = 1'b0;
    case (state_q)
      ST_IDLE: issue_ready = rdy_q;
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        wb_valid    = 1'b1;
        issue_ready = wb_ready;
        if (wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    accept = issue_valid & issue_ready;
    if (accept) state_d = cond_pass ? ST_EXEC : ST_WB;
  end

  // A failed condition goes straight to WB with a zero, non-executed result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_executed <= 1'b0;
      setflags_q  <= 1'b0;
      flags       <= 4'b0000;
    end else if (accept) begin
      wb_rd      <= issue_rd;
      setflags_q <= issue_setflags;
      if (cond_pass) begin
        alu_a  <= issue_a;
        alu_b  <= issue_b;
        alu_op <= issue_op;
      end else begin
        wb_data     <= '0;
        wb_executed <= 1'b0;
      end
    end else if (state_q == ST_EXEC) begin
      wb_data     <= alu_out;
      wb_executed <= 1'b1;
      if (setflags_q) flags <= alu_cond_code;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a behavioural ALU stub and model.
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_op = '0;
  logic [15:0] issue_a = '0, issue_b = '0;
  logic [3:0]  issue_cond = '0;
  logic        issue_setflags = 1'b0;
  logic [2:0]  issue_rd = '0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_op;
  logic [3:0]  alu_cond_code;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_executed;
  logic [3:0]  flags;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  bit ovr_en = 0;
  logic [3:0] ovr_cc = '0;
  bit rnd_on = 0;
  logic [3:0] mflags = '0;

  typedef struct { logic [15:0] d; logic [2:0] rd; bit ex; logic [3:0] f; } exp_t;
  exp_t q[$];

  alu_exec_ctrl #(.DATA_W(16), .OP_W(5), .RD_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_cond(issue_cond),
    .issue_setflags(issue_setflags), .issue_rd(issue_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cond_code(alu_cond_code),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_executed(wb_executed), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Returns {N,Z,C,V, result}.
  function automatic logic [19:0] alu_fn(logic [4:0] op, logic [15:0] a, logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    bit c, v;
    c = 0; v = 0; r = '0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0]; c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB: begin
        r = a - b; c = (a >= b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_AND: r = a & b;
      OP_ORR: r = a | b;
      OP_EOR: r = a ^ b;
      default: r = '0;
    endcase
    return {r[15], (r == 16'h0), c, v, r};
  endfunction

  function automatic bit cond_ok(logic [3:0] f, logic [3:0] c);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;        4'h1: return !z;
      4'h2: return cy;       4'h3: return !cy;
      4'h4: return n;        4'h5: return !n;
      4'h6: return v;        4'h7: return !v;
      4'h8: return cy && !z; 4'h9: return !cy || z;
      4'hA: return n == v;   4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [19:0] alu_res;
  always_comb begin
    alu_res = alu_fn(alu_op, alu_a, alu_b);
    alu_out = alu_res[15:0];
    alu_cond_code = ovr_en ? ovr_cc : alu_res[19:16];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_push(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] c, input bit sf, input logic [2:0] rd);
    exp_t e;
    logic [19:0] r;
    e.rd = rd;
    if (cond_ok(mflags, c)) begin
      r = alu_fn(op, a, b);
      e.d = r[15:0]; e.ex = 1;
      if (sf) mflags = ovr_en ? ovr_cc : r[19:16];
    end else begin
      e.d = '0; e.ex = 0;
    end
    e.f = mflags;
    q.push_back(e);
  endtask

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] c, input bit sf, input logic [2:0] rd,
                       output int acc_cyc);
    issue_op = op; issue_a = a; issue_b = b; issue_cond = c;
    issue_setflags = sf; issue_rd = rd; issue_valid = 1'b1;
    acc_cyc = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (issue_ready) begin
        acc_cyc = cyc;
        model_push(op, a, b, c, sf, rd);
        break;
      end
      @(posedge clk); #1;
    end
    if (acc_cyc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_timeout: no accept within 60 cycles");
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic latency(output int n);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      if (wb_valid) break;
    end
  endtask

  // Monitor: every completed writeback handshake is compared with the queue head.
  initial begin
    int idle = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid && wb_ready) begin
        idle = 0;
        if (q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL wb_unexpected: got rd=%0d data=%0h want no result", wb_rd, wb_data);
        end else begin
          e = q.pop_front();
          check("wb_data", wb_data, e.d);
          check("wb_rd", wb_rd, e.rd);
          check("wb_executed", wb_executed, e.ex);
          check("flags", flags, e.f);
        end
      end else if (q.size() != 0) begin
        idle++;
        if (idle > 40) begin
          n_cmp++; n_fail++;
          $display("FAIL wb_timeout: %0d results outstanding, got no writeback", q.size());
          q.delete(); idle = 0;
        end
      end else idle = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_on) wb_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_prev, lat, seen, rise;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_issue_ready", issue_ready, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_flags", flags, 4'h0);
    check("rst_wb_data", wb_data, 16'h0);
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD, 2-cycle latency
    issue(OP_ADD, 16'h0084, 16'h009d, COND_AL, 1, 3'd1, acc);
    latency(lat);
    check("add_latency", lat, 2);
    check("add_data", wb_data, 16'h0121);
    wait_drain();

    // SUB setting N, then MI executes, PL skipped
    issue(OP_SUB, 16'h0084, 16'h009d, COND_AL, 1, 3'd2, acc);
    wait_drain();
    check("sub_flags", flags, 4'b1000);
    issue(OP_ADD, 16'h0001, 16'h0002, COND_MI, 0, 3'd3, acc);
    wait_drain();
    issue(OP_ADD, 16'h0005, 16'h0006, COND_PL, 1, 3'd4, acc);
    latency(lat);
    check("skip_latency", lat, 1);
    check("skip_executed", wb_executed, 0);
    wait_drain();
    check("skip_flags", flags, 4'b1000);

    // Back-to-back
    acc_prev = -1;
    for (int i = 0; i < 3; i++) begin
      issue(OP_ADD, 16'h0100 * i[15:0], 16'h0011, COND_AL, 0, 3'(i + 5), acc);
      if (i > 0) check("b2b_gap", acc - acc_prev, 2);
      acc_prev = acc;
    end
    wait_drain();

    // Writeback stall
    wb_ready = 1'b0;
    issue(OP_ADD, 16'h1234, 16'h0101, COND_AL, 0, 3'd5, acc);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (wb_valid) seen = 1;
    end
    check("stall_valid_seen", seen, 1);
    for (int k = 0; k < 4; k++) begin
      check("stall_data", wb_data, 16'h1335);
      check("stall_rd", wb_rd, 3'd5);
      check("stall_issue_ready", issue_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    rise = cyc;
    issue(OP_ORR, 16'h00f0, 16'h000f, COND_AL, 0, 3'd6, acc);
    check("stall_resume", acc - rise, 0);
    wait_drain();

    // Condition sweep with Z, then V
    issue(OP_AND, 16'h0000, 16'h0000, COND_AL, 1, 3'd0, acc);
    wait_drain();
    check("sweep_z_flags", flags, 4'b0100);
    for (int i = 0; i < 16; i++)
      issue(OP_ADD, 16'($urandom), 16'($urandom), 4'(i), 0, 3'(i), acc);
    wait_drain();
    ovr_en = 1; ovr_cc = 4'b0001;
    issue(OP_ADD, 16'h0001, 16'h0001, COND_AL, 1, 3'd7, acc);
    wait_drain();
    ovr_en = 0;
    check("sweep_v_flags", flags, 4'b0001);
    for (int i = 0; i < 16; i++)
      issue(OP_EOR, 16'($urandom), 16'($urandom), 4'(i), 0, 3'(i), acc);
    wait_drain();

    // Reset mid-EXEC
    issue(OP_ADD, 16'h0abc, 16'h0001, COND_AL, 1, 3'd3, acc);
    #2;
    rst_n = 1'b0;
    q.delete();
    mflags = '0;
    #1;
    check("mid_rst_wb_valid", wb_valid, 0);
    check("mid_rst_issue_ready", issue_ready, 0);
    check("mid_rst_flags", flags, 4'h0);
    check("mid_rst_alu_a", alu_a, 16'h0);
    check("mid_rst_wb_data", wb_data, 16'h0);
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wb_valid) seen = 1;
    end
    check("post_rst_no_wb", seen, 0);
    @(posedge clk); #1;

    // Random traffic with random writeback backpressure
    rnd_on = 1;
    for (int i = 0; i < 80; i++) begin
      issue(5'($urandom_range(0, 4)), 16'($urandom), 16'($urandom), 4'($urandom),
            1'($urandom), 3'($urandom), acc);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rnd_on = 0;
    @(posedge clk); #1;
    wb_ready = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
